board_referee: RTL and testbench
================================

Name: board_referee

Overview:
- Sequential, parametrised successor to the combinational 3x3 win detector.
- Owns the board for an NxN two-player line game (X/O) and accepts one move per handshake.
- Enforces turn order and cell legality, detects a full-line win on the mover's board, and detects a tie when the board is full.
- Sits between the move source (player input or AI block) and the display/score logic.

Parameters:
- N, 3, board side length; cells = N*N; valid range 3..8.
- FIRST_O, 0, 0: X moves first after reset/new game; 1: O moves first.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- new_game  in  1  clear board and restart; takes effect at next edge
- move_valid  in  1  move offered
- move_ready  out  1  high only in PLAY state
- move_player  in  1  0=X, 1=O
- move_cell  in  CW  cell index = row*N+col, row 0 top; CW=$clog2(N*N)
- x_board  out  N*N  X occupancy, bit i = cell i
- o_board  out  N*N  O occupancy
- turn  out  1  player expected next (0=X, 1=O)
- move_count  out  $clog2(N*N+1)  legal moves accepted this game
- illegal  out  1  one-cycle pulse: last offered move rejected
- move_done  out  1  one-cycle pulse: a legal move has been fully evaluated
- game_over  out  1  high in OVER state
- winner  out  2  00 none, 01 X, 10 O, 11 tie
- win_mask  out  N*N  OR of all completed lines of the winner; 0 otherwise

Behaviour:
- Reset values: boards 0, move_count 0, turn=FIRST_O, illegal 0, move_done 0, game_over 0, winner 00, win_mask 0; state PLAY, so move_ready=1.
- FSM states: PLAY, CHECK, OVER.
- PLAY, accept on move_valid&&move_ready.
  - Illegal if move_player!=turn, or move_cell>=N*N, or the cell is occupied in either board.
  - Illegal move: boards unchanged; illegal=1 next cycle; state stays PLAY.
  - Legal move: set the cell bit in the mover's board at the same edge; move_count+1; go to CHECK.
- CHECK (exactly one cycle, move_ready=0): evaluate the 2N+2 lines (N rows, N columns, 2 diagonals) on the mover's board.
  - Any line complete: winner=mover code, win_mask=OR of completed lines, go to OVER.
  - Else if move_count==N*N: winner=11, win_mask=0, go to OVER.
  - Else toggle turn, go to PLAY.
  - move_done=1 for the cycle after the CHECK edge in all three cases.
- Latency: accept edge E -> outcome registered at edge E+1 -> move_done high during cycle E+1..E+2 -> next move can be accepted at edge E+2.
- OVER: move_ready=0; outputs hold until new_game or rst.
- Priority: rst > new_game > move.
  - new_game in any state clears everything to reset values at the next edge.
  - A move offered in the same cycle as new_game is dropped and raises no illegal pulse.
  - rst or new_game during CHECK aborts the evaluation; no move_done pulse.
- Only the mover's board is checked; the opponent cannot gain a line from the mover's move.
- illegal and move_done are never high together.

Decomposition:
- Shared package board_pkg holds:
  - winner codes WIN_NONE/WIN_X/WIN_O/WIN_TIE
  - player codes PLAYER_X/PLAYER_O
  - FSM state enum
  - a function returning the line mask for line index k given N
- One sub-module, line_checker: combinational; inputs board[N*N-1:0]; outputs any_line and line_or_mask. Generate loops over rows, columns and the two diagonals. This sub-module replaces the fixed-3x3 winner logic.

Test Plan:
- Reset and idle (N=3): assert rst 2 cycles -> move_ready=1, turn=0, boards 0, winner=00, move_count=0.
- X wins top row (N=3): X0,O3,X1,O4,X2 -> after last CHECK: winner=01, win_mask=9'b000000111, game_over=1, move_ready=0, move_count=5, move_done pulses once per move (5 total).
- Illegal moves (N=3): X0 accepted; X1 (wrong turn) -> illegal pulse, boards unchanged; O0 (occupied) -> illegal; O cell 9 (out of range) -> illegal; O4 -> accepted, o_board=9'b000010000.
- Tie (N=3): X0,O1,X2,O4,X3,O5,X7,O6,X8 -> x_board=9'b110001101, o_board=9'b001110010, winner=11, win_mask=0, move_count=9.
- Double line (N=3): X1,O3,X2,O5,X4,O6,X8,O7,X0 -> winner=01, win_mask=9'b100010111 (top row plus main diagonal).
- Controls and width (N=4): new_game asserted together with move_valid mid-game -> move dropped, all outputs back to reset values, no illegal pulse. rst asserted during CHECK -> no move_done. Then X0,O1,X4,O2,X8,O3,X12 -> winner=01, win_mask=16'h1111.

Source files
------------

// File: rtl/board_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | board_pkg : shared codes, FSM states and line-mask helper for the referee  |
// | Revision  : 1.0                                                            |
// +---------------------------------------------------------------------------+
package board_pkg;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_X    = 2'b01;
   localparam logic [1:0] WIN_O    = 2'b10;
   localparam logic [1:0] WIN_TIE  = 2'b11;

   localparam logic PLAYER_X = 1'b0;
   localparam logic PLAYER_O = 1'b1;

   localparam int MAX_CELLS = 64;

   typedef enum logic [1:0] {
      ST_PLAY  = 2'd0,
      ST_CHECK = 2'd1,
      ST_OVER  = 2'd2
   } state_t;

   // Lines 0..n-1 are rows, n..2n-1 columns, 2n main diagonal, 2n+1 anti-diagonal.
   function automatic logic [MAX_CELLS-1:0] line_mask(input int k, input int n);
      logic [MAX_CELLS-1:0] m;
      m = '0;
      for (int i = 0; i < n; i++) begin
         if (k < n)            m[k*n + i]           = 1'b1;
         else if (k < 2*n)     m[i*n + (k - n)]     = 1'b1;
         else if (k == 2*n)    m[i*n + i]           = 1'b1;
         else                  m[i*n + (n - 1 - i)] = 1'b1;
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/board_referee_line_checker.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | line_checker : flags completed rows/columns/diagonals on one player board  |
// | Revision     : 1.0                                                         |
// +---------------------------------------------------------------------------+
module line_checker
   import board_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N*N-1:0] board,
   output logic           any_line,
   output logic [N*N-1:0] line_or_mask
);

   localparam int c_cells = N*N;
   localparam int c_lines = 2*N + 2;

   logic [c_lines-1:0] w_hit;
   logic [c_cells-1:0] w_sel [c_lines];

   generate
      for (genvar r = 0; r < N; r++) begin : g_row
         localparam logic [MAX_CELLS-1:0] c_full = line_mask(r, N);
         localparam logic [c_cells-1:0]   c_mask = c_full[c_cells-1:0];
         assign w_hit[r] = &(board | ~c_mask);
         assign w_sel[r] = w_hit[r] ? c_mask : '0;
      end
      for (genvar c = 0; c < N; c++) begin : g_col
         localparam logic [MAX_CELLS-1:0] c_full = line_mask(N + c, N);
         localparam logic [c_cells-1:0]   c_mask = c_full[c_cells-1:0];
         assign w_hit[N+c] = &(board | ~c_mask);
         assign w_sel[N+c] = w_hit[N+c] ? c_mask : '0;
      end
      for (genvar d = 0; d < 2; d++) begin : g_diag
         localparam logic [MAX_CELLS-1:0] c_full = line_mask(2*N + d, N);
         localparam logic [c_cells-1:0]   c_mask = c_full[c_cells-1:0];
         assign w_hit[2*N+d] = &(board | ~c_mask);
         assign w_sel[2*N+d] = w_hit[2*N+d] ? c_mask : '0;
      end
   endgenerate

   always_comb begin
      line_or_mask = '0;
      for (int k = 0; k < c_lines; k++) begin
         line_or_mask = line_or_mask | w_sel[k];
      end
      any_line = |w_hit;
   end

endmodule
`default_nettype wire

// File: rtl/board_referee.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | board_referee : NxN X/O board owner with turn/legality, win and tie check |
// | Revision      : 1.0                                                        |
// +---------------------------------------------------------------------------+
module board_referee
   import board_pkg::*;
#(
   parameter int N       = 3,
   parameter bit FIRST_O = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        new_game,
   input  logic                        move_valid,
   output logic                        move_ready,
   input  logic                        move_player,
   input  logic [$clog2(N*N)-1:0]      move_cell,
   output logic [N*N-1:0]              x_board,
   output logic [N*N-1:0]              o_board,
   output logic                        turn,
   output logic [$clog2(N*N+1)-1:0]    move_count,
   output logic                        illegal,
   output logic                        move_done,
   output logic                        game_over,
   output logic [1:0]                  winner,
   output logic [N*N-1:0]              win_mask
);

   localparam int                   c_cells = N*N;
   localparam int                   CW      = $clog2(N*N);
   localparam int                   MCW     = $clog2(N*N+1);
   localparam logic [c_cells-1:0]   c_one   = c_cells'(1);

   state_t             r_state;
   logic [c_cells-1:0] r_x;
   logic [c_cells-1:0] r_o;
   logic               r_turn;
   logic [MCW-1:0]     r_count;
   logic               r_illegal;
   logic               r_done;
   logic [1:0]         r_winner;
   logic [c_cells-1:0] r_mask;

   logic [c_cells-1:0] w_onehot;
   logic               w_in_range;
   logic               w_occupied;
   logic               w_legal;
   logic [c_cells-1:0] w_mover_board;
   logic               w_any_line;
   logic [c_cells-1:0] w_line_mask;
   logic               w_full;

   // Out-of-range cells shift the one-hot to zero, so they never alias onto a real cell.
   assign w_onehot      = c_one << move_cell;
   assign w_in_range    = ({1'b0, move_cell} < (CW+1)'(c_cells));
   assign w_occupied    = |(w_onehot & (r_x | r_o));
   assign w_legal       = (move_player == r_turn) && w_in_range && !w_occupied;
   assign w_mover_board = (r_turn == PLAYER_O) ? r_o : r_x;
   assign w_full        = (r_count == MCW'(c_cells));

   line_checker #(.N(N)) u_lines (
      .board        (w_mover_board),
      .any_line     (w_any_line),
      .line_or_mask (w_line_mask)
   );

   always_ff @(posedge clk) begin
      if (rst || new_game) begin
         r_state   <= ST_PLAY;
         r_x       <= '0;
         r_o       <= '0;
         r_turn    <= FIRST_O;
         r_count   <= '0;
         r_illegal <= 1'b0;
         r_done    <= 1'b0;
         r_winner  <= WIN_NONE;
         r_mask    <= '0;
      end else begin
         r_illegal <= 1'b0;
         r_done    <= 1'b0;
         case (r_state)
            ST_PLAY: begin
               if (move_valid) begin
                  if (w_legal) begin
                     if (r_turn == PLAYER_O) r_o <= r_o | w_onehot;
                     else                    r_x <= r_x | w_onehot;
                     r_count <= r_count + MCW'(1);
                     r_state <= ST_CHECK;
                  end else begin
                     r_illegal <= 1'b1;
                  end
               end
            end
            ST_CHECK: begin
               r_done <= 1'b1;
               if (w_any_line) begin
                  r_winner <= (r_turn == PLAYER_O) ? WIN_O : WIN_X;
                  r_mask   <= w_line_mask;
                  r_state  <= ST_OVER;
               end else if (w_full) begin
                  r_winner <= WIN_TIE;
                  r_mask   <= '0;
                  r_state  <= ST_OVER;
               end else begin
                  r_turn  <= ~r_turn;
                  r_state <= ST_PLAY;
               end
            end
            ST_OVER: begin
            end
            default: r_state <= ST_PLAY;
         endcase
      end
   end

   assign move_ready = (r_state == ST_PLAY);
   assign game_over  = (r_state == ST_OVER);
   assign x_board    = r_x;
   assign o_board    = r_o;
   assign turn       = r_turn;
   assign move_count = r_count;
   assign illegal    = r_illegal;
   assign move_done  = r_done;
   assign winner     = r_winner;
   assign win_mask   = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_board_referee.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_board_referee : scripted and random games on N=3 and N=4 referees      |
// | Revision         : 1.0                                                    |
// +---------------------------------------------------------------------------+
module tb_board_referee;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst, a_ng, a_mv, a_mp, a_ready, a_turn, a_ill, a_done, a_over;
   logic [3:0] a_mc, a_cnt;
   logic [8:0] a_x, a_o, a_mask;
   logic [1:0] a_win;

   logic        b_rst, b_ng, b_mv, b_mp, b_ready, b_turn, b_ill, b_done, b_over;
   logic [3:0]  b_mc;
   logic [4:0]  b_cnt;
   logic [15:0] b_x, b_o, b_mask;
   logic [1:0]  b_win;

   board_referee #(.N(3), .FIRST_O(1'b0)) dut3 (
      .clk(clk), .rst(a_rst), .new_game(a_ng), .move_valid(a_mv), .move_ready(a_ready),
      .move_player(a_mp), .move_cell(a_mc), .x_board(a_x), .o_board(a_o), .turn(a_turn),
      .move_count(a_cnt), .illegal(a_ill), .move_done(a_done), .game_over(a_over),
      .winner(a_win), .win_mask(a_mask)
   );

   board_referee #(.N(4), .FIRST_O(1'b0)) dut4 (
      .clk(clk), .rst(b_rst), .new_game(b_ng), .move_valid(b_mv), .move_ready(b_ready),
      .move_player(b_mp), .move_cell(b_mc), .x_board(b_x), .o_board(b_o), .turn(b_turn),
      .move_count(b_cnt), .illegal(b_ill), .move_done(b_done), .game_over(b_over),
      .winner(b_win), .win_mask(b_mask)
   );

   int checks = 0;
   int failures = 0;
   int n_done;

   // Reference model of the game on an n x n board
   int          m_n;
   logic [63:0] m_x, m_o, m_mask;
   int          m_turn, m_count, m_winner;
   bit          m_over;

   logic [63:0] obs_x, obs_o, obs_mask;
   int          obs_turn, obs_count, obs_winner, obs_ready, obs_ill, obs_done, obs_over;

   function automatic logic [63:0] lines_of(input logic [63:0] b, input int n);
      logic [63:0] acc, line;
      bit full;
      acc = '0;
      for (int r = 0; r < n; r++) begin
         line = '0; full = 1;
         for (int c = 0; c < n; c++) begin line[r*n+c] = 1'b1; if (!b[r*n+c]) full = 0; end
         if (full) acc |= line;
      end
      for (int c = 0; c < n; c++) begin
         line = '0; full = 1;
         for (int r = 0; r < n; r++) begin line[r*n+c] = 1'b1; if (!b[r*n+c]) full = 0; end
         if (full) acc |= line;
      end
      line = '0; full = 1;
      for (int i = 0; i < n; i++) begin line[i*n+i] = 1'b1; if (!b[i*n+i]) full = 0; end
      if (full) acc |= line;
      line = '0; full = 1;
      for (int i = 0; i < n; i++) begin line[i*n+n-1-i] = 1'b1; if (!b[i*n+n-1-i]) full = 0; end
      if (full) acc |= line;
      return acc;
   endfunction

   task automatic model_reset();
      m_x = '0; m_o = '0; m_mask = '0;
      m_turn = 0; m_count = 0; m_winner = 0; m_over = 0;
   endtask

   task automatic model_move(input int p, input int c, output int e_ill, output int e_done);
      logic [63:0] lm;
      e_ill = 0; e_done = 0;
      if (m_over) return;
      if (p != m_turn || c >= m_n*m_n || m_x[c] || m_o[c]) begin
         e_ill = 1;
         return;
      end
      if (p != 0) m_o[c] = 1'b1; else m_x[c] = 1'b1;
      m_count++;
      e_done = 1;
      lm = lines_of((p != 0) ? m_o : m_x, m_n);
      if (lm != 0) begin
         m_winner = (p != 0) ? 2 : 1; m_mask = lm; m_over = 1;
      end else if (m_count == m_n*m_n) begin
         m_winner = 3; m_mask = '0; m_over = 1;
      end else begin
         m_turn ^= 1;
      end
   endtask

   task automatic sample();
      if (m_n == 3) begin
         obs_x = 64'(a_x); obs_o = 64'(a_o); obs_mask = 64'(a_mask);
         obs_turn = int'(a_turn); obs_count = int'(a_cnt); obs_winner = int'(a_win);
         obs_ready = int'(a_ready); obs_ill = int'(a_ill); obs_done = int'(a_done);
         obs_over = int'(a_over);
      end else begin
         obs_x = 64'(b_x); obs_o = 64'(b_o); obs_mask = 64'(b_mask);
         obs_turn = int'(b_turn); obs_count = int'(b_cnt); obs_winner = int'(b_win);
         obs_ready = int'(b_ready); obs_ill = int'(b_ill); obs_done = int'(b_done);
         obs_over = int'(b_over);
      end
   endtask

   task automatic idle_inputs();
      a_ng = 0; a_mv = 0; a_mp = 0; a_mc = '0;
      b_ng = 0; b_mv = 0; b_mp = 0; b_mc = '0;
   endtask

   task automatic drive(input int p, input int c, input bit ng);
      if (m_n == 3) begin a_mv = 1; a_mp = p[0]; a_mc = c[3:0]; a_ng = ng; end
      else          begin b_mv = 1; b_mp = p[0]; b_mc = c[3:0]; b_ng = ng; end
   endtask

   task automatic new_game_pulse();
      if (m_n == 3) a_ng = 1; else b_ng = 1;
      @(posedge clk); #1;
      idle_inputs();
      model_reset();
   endtask

   // Offer one move, then compare pulses and the full visible state with the model.
   task automatic play(input string name, input int p, input int c);
      int ei, ed, ill1, done1, rdy1;
      drive(p, c, 0);
      @(posedge clk); #1;
      idle_inputs();
      sample();
      ill1 = obs_ill; done1 = obs_done; rdy1 = obs_ready;
      model_move(p, c, ei, ed);
      checks++;
      if (ill1 !== ei) begin failures++; $display("FAIL %s illegal p=%0d c=%0d: got %0d want %0d", name, p, c, ill1, ei); end
      checks++;
      if (done1 !== 0 || (ed == 1 && rdy1 !== 0)) begin
         failures++; $display("FAIL %s check_cycle p=%0d c=%0d: done=%0d ready=%0d want done=0 ready=0", name, p, c, done1, rdy1);
      end
      @(posedge clk); #1;
      sample();
      checks++;
      if (obs_done !== ed || obs_ill !== 0) begin
         failures++; $display("FAIL %s move_done p=%0d c=%0d: got done=%0d ill=%0d want done=%0d ill=0", name, p, c, obs_done, obs_ill, ed);
      end
      if (obs_done == 1) n_done++;
      checks++;
      if (obs_x !== m_x || obs_o !== m_o) begin
         failures++; $display("FAIL %s boards: got x=%h o=%h want x=%h o=%h", name, obs_x, obs_o, m_x, m_o);
      end
      checks++;
      if (obs_turn !== m_turn || obs_count !== m_count || obs_winner !== m_winner || obs_mask !== m_mask ||
          obs_over !== int'(m_over) || obs_ready !== int'(!m_over)) begin
         failures++;
         $display("FAIL %s status: got turn=%0d cnt=%0d win=%0d mask=%h over=%0d rdy=%0d want turn=%0d cnt=%0d win=%0d mask=%h over=%0d",
                  name, obs_turn, obs_count, obs_winner, obs_mask, obs_over, obs_ready, m_turn, m_count, m_winner, m_mask, m_over);
      end
   endtask

   task automatic test_reset();
      a_rst = 1; b_rst = 1;
      repeat (2) @(posedge clk);
      #1;
      a_rst = 0; b_rst = 0;
      for (int s = 3; s <= 4; s++) begin
         m_n = s;
         model_reset();
         sample();
         checks++;
         if (obs_ready !== 1 || obs_turn !== 0 || obs_x !== 0 || obs_o !== 0 || obs_winner !== 0 ||
             obs_count !== 0 || obs_mask !== 0 || obs_over !== 0 || obs_ill !== 0 || obs_done !== 0) begin
            failures++;
            $display("FAIL reset n=%0d: got rdy=%0d turn=%0d x=%h o=%h win=%0d cnt=%0d mask=%h over=%0d ill=%0d done=%0d want 1/0/0/0/0/0/0/0/0/0",
                     s, obs_ready, obs_turn, obs_x, obs_o, obs_winner, obs_count, obs_mask, obs_over, obs_ill, obs_done);
         end
      end
   endtask

   task automatic test_x_top_row();
      int ps[5] = '{0, 1, 0, 1, 0};
      int cs[5] = '{0, 3, 1, 4, 2};
      m_n = 3; new_game_pulse(); n_done = 0;
      for (int i = 0; i < 5; i++) play("top_row", ps[i], cs[i]);
      checks++;
      if (obs_winner !== 1 || obs_mask !== 64'h7 || obs_over !== 1 || obs_ready !== 0 || obs_count !== 5 || n_done !== 5) begin
         failures++;
         $display("FAIL top_row_final: got win=%0d mask=%h over=%0d rdy=%0d cnt=%0d dones=%0d want 1 7 1 0 5 5",
                  obs_winner, obs_mask, obs_over, obs_ready, obs_count, n_done);
      end
   endtask

   task automatic test_illegal();
      int ps[5] = '{0, 0, 1, 1, 1};
      int cs[5] = '{0, 1, 0, 9, 4};
      m_n = 3; new_game_pulse();
      for (int i = 0; i < 5; i++) play("illegal", ps[i], cs[i]);
      checks++;
      if (obs_o !== 64'h10 || obs_x !== 64'h1 || obs_count !== 2) begin
         failures++; $display("FAIL illegal_final: got x=%h o=%h cnt=%0d want x=1 o=10 cnt=2", obs_x, obs_o, obs_count);
      end
   endtask

   task automatic test_tie();
      int cs[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      m_n = 3; new_game_pulse();
      for (int i = 0; i < 9; i++) play("tie", i % 2, cs[i]);
      checks++;
      if (obs_x !== 64'h18D || obs_o !== 64'h072 || obs_winner !== 3 || obs_mask !== 0 || obs_count !== 9) begin
         failures++;
         $display("FAIL tie_final: got x=%h o=%h win=%0d mask=%h cnt=%0d want 18d 072 3 0 9", obs_x, obs_o, obs_winner, obs_mask, obs_count);
      end
   endtask

   task automatic test_double_line();
      int cs[9] = '{1, 3, 2, 5, 4, 6, 8, 7, 0};
      m_n = 3; new_game_pulse();
      for (int i = 0; i < 9; i++) play("double", i % 2, cs[i]);
      checks++;
      if (obs_winner !== 1 || obs_mask !== 64'h117) begin
         failures++; $display("FAIL double_final: got win=%0d mask=%h want 1 117", obs_winner, obs_mask);
      end
   endtask

   task automatic test_controls_n4();
      int cs[7] = '{0, 1, 4, 2, 8, 3, 12};
      m_n = 4; new_game_pulse();
      play("ctl_pre", 0, 0);
      play("ctl_pre", 1, 1);
      // Move offered together with new_game must vanish without a trace.
      drive(0, 5, 1);
      @(posedge clk); #1;
      idle_inputs(); model_reset(); sample();
      checks++;
      if (obs_ill !== 0 || obs_x !== 0 || obs_o !== 0 || obs_count !== 0 || obs_turn !== 0 || obs_ready !== 1) begin
         failures++;
         $display("FAIL new_game_drop: got ill=%0d x=%h o=%h cnt=%0d turn=%0d rdy=%0d want 0 0 0 0 0 1",
                  obs_ill, obs_x, obs_o, obs_count, obs_turn, obs_ready);
      end
      @(posedge clk); #1; sample();
      checks++;
      if (obs_ill !== 0 || obs_done !== 0) begin
         failures++; $display("FAIL new_game_after: got ill=%0d done=%0d want 0 0", obs_ill, obs_done);
      end
      drive(0, 5, 0);
      @(posedge clk); #1;
      idle_inputs(); sample();
      checks++;
      if (obs_ready !== 0 || obs_x !== 64'h20) begin
         failures++; $display("FAIL rst_setup: got rdy=%0d x=%h want 0 20", obs_ready, obs_x);
      end
      b_rst = 1;
      @(posedge clk); #1;
      b_rst = 0; sample();
      checks++;
      if (obs_done !== 0 || obs_x !== 0 || obs_count !== 0 || obs_ready !== 1 || obs_winner !== 0) begin
         failures++;
         $display("FAIL rst_in_check: got done=%0d x=%h cnt=%0d rdy=%0d win=%0d want 0 0 0 1 0", obs_done, obs_x, obs_count, obs_ready, obs_winner);
      end
      @(posedge clk); #1; sample();
      checks++;
      if (obs_done !== 0) begin failures++; $display("FAIL rst_no_done: got %0d want 0", obs_done); end
      model_reset();
      for (int i = 0; i < 7; i++) play("n4_col", i % 2, cs[i]);
      checks++;
      if (obs_winner !== 1 || obs_mask !== 64'h1111 || obs_count !== 7) begin
         failures++; $display("FAIL n4_col_final: got win=%0d mask=%h cnt=%0d want 1 1111 7", obs_winner, obs_mask, obs_count);
      end
   endtask

   task automatic test_random();
      int p, c, k;
      int empties[$];
      for (int s = 3; s <= 4; s++) begin
         m_n = s;
         for (int g = 0; g < 6; g++) begin
            new_game_pulse();
            for (int mv = 0; mv < 60 && !m_over; mv++) begin
               p = ($urandom_range(0, 4) != 0) ? m_turn : 1 - m_turn;
               if ($urandom_range(0, 3) != 0) begin
                  empties.delete();
                  for (int i = 0; i < s*s; i++) if (!m_x[i] && !m_o[i]) empties.push_back(i);
                  k = $urandom_range(0, empties.size() - 1);
                  c = empties[k];
               end else begin
                  c = $urandom_range(0, 15);
               end
               play("random", p, c);
            end
            // A move offered after the game ended must be ignored.
            play("random_over", m_turn, $urandom_range(0, 15));
         end
      end
   endtask

   initial begin
      idle_inputs();
      a_rst = 1; b_rst = 1;
      m_n = 3;
      model_reset();
      n_done = 0;
      test_reset();
      test_x_top_row();
      test_illegal();
      test_tie();
      test_double_line();
      test_controls_n4();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
